// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and helper functions for the pipeline hazard controller.
// Result classes, forward-select codes, MD tracker states, Tnew/match helpers.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RES_NW  = 2'b00,
    RES_ALU = 2'b01,
    RES_DM  = 2'b10,
    RES_PC  = 2'b11
  } res_t;

  typedef enum logic [1:0] {
    FWD_GRF = 2'b00,
    FWD_E   = 2'b01,
    FWD_M   = 2'b10,
    FWD_W   = 2'b11
  } fwd_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // A source that is not read at all gets a Tuse larger than any Tnew.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  function automatic logic [1:0] tnew_e_of(input logic [1:0] res);
    case (res)
      RES_ALU: return 2'd1;
      RES_DM:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tnew_m_of(input logic [1:0] res);
    return (res == RES_DM) ? 2'd1 : 2'd0;
  endfunction

  // Register 0 is never a producer, so it can never match.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst,
                                   input logic [1:0] res);
    return (src == dst) && (dst != 5'd0) && (res != RES_NW);
  endfunction

  // Youngest producer wins; E is only a legal source when the caller allows it.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] a3_e, input logic [1:0] res_e,
                                         input logic [4:0] a3_m, input logic [1:0] res_m,
                                         input logic [4:0] a3_w, input logic [1:0] res_w,
                                         input logic       allow_e);
    if (allow_e && reg_hit(src, a3_e, res_e) && (res_e == RES_PC))
      return FWD_E;
    else if (reg_hit(src, a3_m, res_m) && ((res_m == RES_ALU) || (res_m == RES_PC)))
      return FWD_M;
    else if (reg_hit(src, a3_w, res_w))
      return FWD_W;
    else
      return FWD_GRF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_tracker.sv
// HI/LO unit occupancy tracker: counts down the mult/div latency after an op enters E.
// A new op arriving while busy reloads the count (latest op wins).
module md_busy_tracker
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_e,
  input  logic md_is_div_e,
  output logic md_busy
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  md_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   load_val;

  assign load_val = md_is_div_e ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md_start_e) begin
            state <= MD_BUSY;
            cnt   <= load_val;
          end
        end
        MD_BUSY: begin
          if (md_start_e) begin
            cnt <= load_val;
          end else if (cnt == CNT_W'(1)) begin
            state <= MD_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= MD_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Busy is visible in the same cycle the op enters E, not one cycle later.
  assign md_busy = md_start_e || (state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: D-stage stall, forwarding selects for D/E/M, and HI/LO interlock.
// Everything except the MD tracker state is combinational from the current stage tags.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tuse_rs0,
  input  logic       tuse_rs1,
  input  logic       tuse_rt0,
  input  logic       tuse_rt1,
  input  logic       tuse_rt2,
  input  logic [4:0] a1_d,
  input  logic [4:0] a2_d,
  input  logic [4:0] a1_e,
  input  logic [4:0] a2_e,
  input  logic [4:0] a2_m,
  input  logic [4:0] a3_e,
  input  logic [4:0] a3_m,
  input  logic [4:0] a3_w,
  input  logic [1:0] res_e,
  input  logic [1:0] res_m,
  input  logic [1:0] res_w,
  input  logic       md_start_e,
  input  logic       md_is_div_e,
  input  logic       md_use_d,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m,
  output logic       md_busy
);

  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic [1:0] tnew_e;
  logic [1:0] tnew_m;
  logic       stall_rs;
  logic       stall_rt;
  logic       data_stall;

  // Earliest use decides; a reader only stalls when its producer is not ready in time.
  assign tuse_rs = tuse_rs0 ? 2'd0 : (tuse_rs1 ? 2'd1 : TUSE_NONE);
  assign tuse_rt = tuse_rt0 ? 2'd0 : (tuse_rt1 ? 2'd1 : (tuse_rt2 ? 2'd2 : TUSE_NONE));

  assign tnew_e = tnew_e_of(res_e);
  assign tnew_m = tnew_m_of(res_m);

  assign stall_rs = (reg_hit(a1_d, a3_e, res_e) && (tnew_e > tuse_rs)) ||
                    (reg_hit(a1_d, a3_m, res_m) && (tnew_m > tuse_rs));
  assign stall_rt = (reg_hit(a2_d, a3_e, res_e) && (tnew_e > tuse_rt)) ||
                    (reg_hit(a2_d, a3_m, res_m) && (tnew_m > tuse_rt));

  assign data_stall = stall_rs || stall_rt;
  assign stall      = data_stall || (md_use_d && md_busy);

  assign fwd_rs_d = fwd_sel(a1_d, a3_e, res_e, a3_m, res_m, a3_w, res_w, 1'b1);
  assign fwd_rt_d = fwd_sel(a2_d, a3_e, res_e, a3_m, res_m, a3_w, res_w, 1'b1);
  assign fwd_rs_e = fwd_sel(a1_e, a3_e, res_e, a3_m, res_m, a3_w, res_w, 1'b0);
  assign fwd_rt_e = fwd_sel(a2_e, a3_e, res_e, a3_m, res_m, a3_w, res_w, 1'b0);
  assign fwd_rt_m = reg_hit(a2_m, a3_w, res_w);

  md_busy_tracker #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_tracker (
    .clk        (clk),
    .reset      (reset),
    .md_start_e (md_start_e),
    .md_is_div_e(md_is_div_e),
    .md_busy    (md_busy)
  );

endmodule
